// File: rtl/question_gen_if.sv
// Handshake/bus bundle between the READY/control stages and the question generator.
// master: control side driving OK/NUM/STATE; slave: question generator driving the question.
// Pure wiring, no storage.
interface question_gen_if;
  logic       ok;
  logic [3:0] num;
  logic [3:0] state;
  logic [7:0] q_value;
  logic [3:0] fact_a;
  logic [3:0] fact_b;
  logic       q_valid;
  logic       q_done;
  logic [3:0] sec_left;

  modport master (
    output ok, num, state,
    input  q_value, fact_a, fact_b, q_valid, q_done, sec_left
  );

  modport slave (
    input  ok, num, state,
    output q_value, fact_a, fact_b, q_valid, q_done, sec_left
  );
endinterface

// File: rtl/question_gen.sv
// Builds a factorization question: two primes from an LFSR/NUM seed, shift-add product, timed display.
// Latency: product/valid/seconds appear on the 6th edge after the edge that samples the OK rise.
// No backpressure: a result STATE aborts or releases the question; OK is edge-triggered from IDLE only.
module question_gen #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned SHOW_SEC = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  question_gen_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_SHOW,
    S_HOLD
  } state_e;

  state_e        state_q;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          ok_q;
  logic          armed_q;
  logic [7:0]    seed_q;
  logic [3:0]    fact_a_q, fact_b_q;
  logic [7:0]    acc_q;
  logic [2:0]    bit_q;
  logic [TW-1:0] tick_q;
  logic [7:0]    q_value_q;
  logic          q_valid_q;
  logic          q_done_q;
  logic [3:0]    sec_left_q;

  logic          start;
  logic          result_state;
  logic [7:0]    seed_d;
  logic [3:0]    pa, pb;
  logic [7:0]    addend;

  // Index 6 and 7 fold back onto 2 and 3 so every 3-bit index is a valid prime.
  function automatic logic [3:0] prime_of(input logic [2:0] idx);
    case (idx)
      3'd0:    prime_of = 4'd2;
      3'd1:    prime_of = 4'd3;
      3'd2:    prime_of = 4'd5;
      3'd3:    prime_of = 4'd7;
      3'd4:    prime_of = 4'd11;
      3'd5:    prime_of = 4'd13;
      3'd6:    prime_of = 4'd2;
      default: prime_of = 4'd3;
    endcase
  endfunction

  // Galois step for x^8+x^6+x^5+x^4+1, seed/start decode, prime lookup and partial product.
  always_comb begin
    lfsr_d = {lfsr_q[6], lfsr_q[5] ^ lfsr_q[7], lfsr_q[4] ^ lfsr_q[7],
              lfsr_q[3] ^ lfsr_q[7], lfsr_q[2], lfsr_q[1], lfsr_q[0], lfsr_q[7]};
    // armed_q blocks a start from an OK that was already high when reset released
    start  = bus.ok & ~ok_q & armed_q;
    result_state = (bus.state == 4'd6) || (bus.state == 4'd8) || (bus.state == 4'd9) ||
                   (bus.state == 4'd10) || (bus.state == 4'd11);
    seed_d = lfsr_q ^ {4'h0, bus.num};
    if (seed_d == 8'h00) begin
      seed_d = 8'h01;
    end
    pa     = prime_of(seed_q[2:0]);
    pb     = prime_of(seed_q[5:3]);
    addend = 8'h00;
    if (fact_b_q[bit_q[1:0]]) begin
      addend = {4'h0, fact_a_q} << bit_q[1:0];
    end
  end

  // Free-running LFSR and OK edge/arming history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q  <= 8'hA5;
      ok_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      ok_q    <= bus.ok;
      armed_q <= armed_q | ~bus.ok;
    end
  end

  // Question FSM with registered outputs; a result STATE wins over any in-flight step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      seed_q     <= 8'h00;
      fact_a_q   <= 4'h0;
      fact_b_q   <= 4'h0;
      acc_q      <= 8'h00;
      bit_q      <= 3'd0;
      tick_q     <= '0;
      q_value_q  <= 8'h00;
      q_valid_q  <= 1'b0;
      q_done_q   <= 1'b0;
      sec_left_q <= 4'h0;
    end else begin
      q_done_q <= 1'b0;
      if (state_q != S_IDLE && result_state) begin
        state_q    <= S_IDLE;
        fact_a_q   <= 4'h0;
        fact_b_q   <= 4'h0;
        q_value_q  <= 8'h00;
        q_valid_q  <= 1'b0;
        sec_left_q <= 4'h0;
      end else begin
        case (state_q)
          S_IDLE: begin
            fact_a_q   <= 4'h0;
            fact_b_q   <= 4'h0;
            q_value_q  <= 8'h00;
            q_valid_q  <= 1'b0;
            sec_left_q <= 4'h0;
            if (start) begin
              seed_q  <= seed_d;
              state_q <= S_LOAD;
            end
          end
          S_LOAD: begin
            fact_a_q <= (pa <= pb) ? pa : pb;
            fact_b_q <= (pa <= pb) ? pb : pa;
            acc_q    <= 8'h00;
            bit_q    <= 3'd0;
            state_q  <= S_MUL;
          end
          S_MUL: begin
            // four accumulate edges, then one edge to publish the product
            if (bit_q == 3'd4) begin
              q_value_q  <= acc_q;
              q_valid_q  <= 1'b1;
              sec_left_q <= 4'(SHOW_SEC);
              tick_q     <= '0;
              state_q    <= S_SHOW;
            end else begin
              acc_q <= acc_q + addend;
              bit_q <= bit_q + 3'd1;
            end
          end
          S_SHOW: begin
            if (tick_q == TW'(TICK_DIV - 1)) begin
              tick_q     <= '0;
              sec_left_q <= sec_left_q - 4'd1;
              if (sec_left_q == 4'd1) begin
                q_done_q <= 1'b1;
                state_q  <= S_HOLD;
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
          S_HOLD: begin
            sec_left_q <= 4'h0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.q_value  = q_value_q;
  assign bus.fact_a   = fact_a_q;
  assign bus.fact_b   = fact_b_q;
  assign bus.q_valid  = q_valid_q;
  assign bus.q_done   = q_done_q;
  assign bus.sec_left = sec_left_q;

endmodule
